// File: rtl/uart_pkg.sv
// Shared encodings and default parameters for the UART with transmit/receive FIFOs.
package uart_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_START = 2'd1,
        STATE_DATA  = 2'd2,
        STATE_STOP  = 2'd3
    } uart_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 217;
    localparam int DEFAULT_FIFO_DEPTH   = 16;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read and registered full/empty flags.
module uart_sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_wr;
    logic             do_rd;

    always_comb begin
        do_wr    = wr_en && !full_q;
        do_rd    = rd_en && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_rd && !do_wr) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d  = (count_d == CNT_W'(FIFO_DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage carries no reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = empty_q ? '0 : mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/uart_with_fifo_top.sv
// 8N1 UART: host bytes go through a TX FIFO to the serialiser; the deserialiser
// fills an RX FIFO that the host reads first-word-fall-through.
module uart_with_fifo_top
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_wr_en,
    input  logic              rx_rd_en,
    input  logic              rx,
    output logic              tx,
    output logic [DATA_W-1:0] rx_data,
    output logic              tx_fifo_full,
    output logic              rx_fifo_empty
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    logic [DATA_W-1:0] tx_head;
    logic              tx_fifo_empty;
    logic              tx_pop;
    logic              rx_fifo_full;
    logic              rx_push;

    uart_state_e       tx_state_q, tx_state_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shreg_q, tx_shreg_d;
    logic              tx_q, tx_d;

    logic              rx_s1_q, rx_s1_d;
    logic              rx_s2_q, rx_s2_d;
    uart_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_shreg_q, rx_shreg_d;

    uart_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tx_wr_en),
        .wr_data (tx_data),
        .rd_en   (tx_pop),
        .rd_data (tx_head),
        .full    (tx_fifo_full),
        .empty   (tx_fifo_empty)
    );

    uart_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rx_push),
        .wr_data (rx_shreg_q),
        .rd_en   (rx_rd_en),
        .rd_data (rx_data),
        .full    (rx_fifo_full),
        .empty   (rx_fifo_empty)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shreg_d = tx_shreg_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            STATE_IDLE: begin
                if (!tx_fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shreg_d = tx_head;
                    tx_cnt_d   = '0;
                    tx_state_d = STATE_START;
                end
            end
            STATE_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = STATE_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            STATE_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shreg_d = tx_shreg_q >> 1;
                    if (tx_bit_q == BIT_LAST) begin
                        tx_state_d = STATE_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + BW'(1);
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            STATE_STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    // Chain straight into the next start bit so queued bytes leave no idle gap.
                    if (!tx_fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_shreg_d = tx_head;
                        tx_state_d = STATE_START;
                    end else begin
                        tx_state_d = STATE_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = STATE_IDLE;
        endcase
        // Line level follows the next state so tx is glitch-free and aligned with the state register.
        unique case (tx_state_d)
            STATE_START: tx_d = 1'b0;
            STATE_DATA:  tx_d = tx_shreg_d[0];
            default:     tx_d = 1'b1;
        endcase
    end

    always_comb begin
        rx_s1_d    = rx;
        rx_s2_d    = rx_s1_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shreg_d = rx_shreg_q;
        rx_push    = 1'b0;
        unique case (rx_state_q)
            STATE_IDLE: begin
                if (!rx_s2_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = STATE_START;
                end
            end
            STATE_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? STATE_IDLE : STATE_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            STATE_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shreg_d = {rx_s2_q, rx_shreg_q[DATA_W-1:1]};
                    if (rx_bit_q == BIT_LAST) begin
                        rx_state_d = STATE_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + BW'(1);
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            STATE_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_push    = rx_s2_q && !rx_fifo_full;
                    rx_state_d = STATE_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= STATE_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shreg_q <= '0;
            tx_q       <= 1'b1;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= STATE_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shreg_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shreg_q <= tx_shreg_d;
            tx_q       <= tx_d;
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shreg_q <= rx_shreg_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_uart_with_fifo_top.sv
// Directed bench for uart_with_fifo_top: reset, loopback, bit timing, TX FIFO full, RX framing and glitch.
module tb_uart_with_fifo_top;

    localparam int CPB = 217;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr_en = 1'b0;
    logic       rx_rd_en = 1'b0;
    logic       rx;
    logic       tx;
    logic [7:0] rx_data;
    logic       tx_fifo_full;
    logic       rx_fifo_empty;

    logic       loop_en = 1'b0;
    logic       rx_drv = 1'b1;

    int total = 0;
    int bad = 0;

    logic [7:0] mon_q[$];
    logic [7:0] mon_b;

    always #10 clk = ~clk;

    assign rx = loop_en ? tx : rx_drv;

    uart_with_fifo_top dut (
        .clk           (clk),
        .rst           (rst),
        .tx_data       (tx_data),
        .tx_wr_en      (tx_wr_en),
        .rx_rd_en      (rx_rd_en),
        .rx            (rx),
        .tx            (tx),
        .rx_data       (rx_data),
        .tx_fifo_full  (tx_fifo_full),
        .rx_fifo_empty (rx_fifo_empty)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=0x%0h", tag, got);
        end
    endtask

    // Independent 8N1 decoder on tx: finds the start bit, then samples at bit centres.
    always begin
        @(negedge clk);
        if (tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            if (tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mon_b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx === 1'b1) mon_q.push_back(mon_b);
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_wr_en = 1'b1;
        @(negedge clk);
        tx_wr_en = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (stop_len) @(negedge clk);
        rx_drv = 1'b1;
        repeat (300) @(negedge clk);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        @(negedge clk);
        check_val({tag, "_empty"}, {31'd0, rx_fifo_empty}, 32'd0);
        check_val({tag, "_data"}, {24'd0, rx_data}, {24'd0, exp});
        rx_rd_en = 1'b1;
        @(negedge clk);
        rx_rd_en = 1'b0;
        check_val({tag, "_after_pop_empty"}, {31'd0, rx_fifo_empty}, 32'd1);
    endtask

    initial begin
        int cnt;
        int lat;
        logic [7:0] loop_bytes [4];
        loop_bytes[0] = 8'h41; loop_bytes[1] = 8'h42;
        loop_bytes[2] = 8'h43; loop_bytes[3] = 8'h44;

        // Reset held for 5 cycles
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_tx", {31'd0, tx}, 32'd1);
        check_val("rst_tx_full", {31'd0, tx_fifo_full}, 32'd0);
        check_val("rst_rx_empty", {31'd0, rx_fifo_empty}, 32'd1);
        check_val("rst_rx_data", {24'd0, rx_data}, 32'h00);

        // 0x55: start, 1,0,1,0,1,0,1,0, stop -- every bit toggles the line
        mon_q.delete();
        push_byte(8'h55);
        lat = 1;
        while (tx !== 1'b0 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_val("b55_start_latency_le3", {31'd0, lat <= 3}, 32'd1);
        for (int s = 0; s < 9; s++) begin
            logic lvl;
            lvl = s[0];
            cnt = 0;
            while (tx === lvl && cnt < 500) begin
                @(negedge clk);
                cnt++;
            end
            check_val($sformatf("b55_seg%0d_len", s),
                      (cnt >= CPB - 1 && cnt <= CPB + 1) ? CPB : cnt, CPB);
        end
        cnt = 0;
        while (tx === 1'b1 && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check_val("b55_stop_then_idle_high", cnt, 300);
        check_val("b55_decoded_count", mon_q.size(), 1);
        if (mon_q.size() > 0) check_val("b55_decoded", {24'd0, mon_q[0]}, 32'h55);

        // Loopback: four consecutive single-cycle writes
        loop_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tx_data  = loop_bytes[i];
            tx_wr_en = 1'b1;
            @(negedge clk);
        end
        tx_wr_en = 1'b0;
        repeat (10000) @(negedge clk);
        check_val("loop_rx_not_empty", {31'd0, rx_fifo_empty}, 32'd0);
        rx_rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("loop_rd%0d", i), {24'd0, rx_data}, {24'd0, loop_bytes[i]});
            @(negedge clk);
        end
        rx_rd_en = 1'b0;
        check_val("loop_rx_empty_after", {31'd0, rx_fifo_empty}, 32'd1);
        loop_en = 1'b0;
        repeat (500) @(negedge clk);

        // 17 writes fill transmitter plus 16 FIFO entries; the 18th (0xEE) is dropped
        mon_q.delete();
        @(negedge clk);
        tx_data  = 8'h10;
        tx_wr_en = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 16) check_val("full_after_16", {31'd0, tx_fifo_full}, 32'd0);
            if (k == 17) check_val("full_after_17", {31'd0, tx_fifo_full}, 32'd1);
            tx_data = (k < 17) ? 8'(8'h10 + k) : 8'hEE;
        end
        @(negedge clk);
        tx_wr_en = 1'b0;
        check_val("full_after_ignored_write", {31'd0, tx_fifo_full}, 32'd1);
        cnt = 0;
        while (mon_q.size() < 17 && cnt < 45000) begin
            @(negedge clk);
            cnt++;
        end
        check_val("burst_wait_in_budget", {31'd0, cnt < 45000}, 32'd1);
        repeat (2500) @(negedge clk);
        check_val("burst_byte_count", mon_q.size(), 17);
        for (int i = 0; i < 17 && i < mon_q.size(); i++) begin
            check_val($sformatf("burst_byte%0d", i), {24'd0, mon_q[i]}, 32'h10 + i);
        end
        check_val("burst_tx_full_cleared", {31'd0, tx_fifo_full}, 32'd0);

        // Framing error: 0xA5 with a low stop bit, released after its centre
        send_frame(8'hA5, 1'b0, (3 * CPB) / 4);
        repeat (500) @(negedge clk);
        check_val("frame_err_rx_empty", {31'd0, rx_fifo_empty}, 32'd1);
        send_frame(8'h3C, 1'b1, CPB);
        pop_expect("rx_3c", 8'h3C);

        // One-cycle low glitch must not start a frame
        @(negedge clk);
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (2500) @(negedge clk);
        check_val("glitch_rx_empty", {31'd0, rx_fifo_empty}, 32'd1);
        send_frame(8'h96, 1'b1, CPB);
        pop_expect("rx_after_glitch", 8'h96);

        // Reset mid-frame aborts the byte; line returns high and stays idle
        push_byte(8'h00);
        repeat (600) @(negedge clk);
        check_val("midframe_tx_low", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midframe_rst_tx", {31'd0, tx}, 32'd1);
        repeat (2500) @(negedge clk);
        check_val("midframe_tx_stays_idle", {31'd0, tx}, 32'd1);
        check_val("midframe_rx_empty", {31'd0, rx_fifo_empty}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
